// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow of the EX and MEM destination registers. From that shadow it
// drives the registered EX operand-mux selects (0=regfile, 1=EX/MEM ALU result,
// 2=MEM/WB writeback data) and the combinational stall for PC and IF/ID.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              id_flush,
  input  logic              mem_hold,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  load_use_cnt
);

  // Shadow of the EX and MEM slots. A bubble has wen=0 and load=0.
  // The MEM slot keeps no load flag: once a load reaches MEM its result is
  // forwarded from MEM/WB, so whether it was a load no longer matters.
  logic [REG_AW-1:0] ex_dst_reg;
  logic              ex_wen_reg;
  logic              ex_load_reg;
  logic [REG_AW-1:0] mem_dst_reg;
  logic              mem_wen_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic lu;
  logic bubble;

  // Source operands packed by index: 0 = rs (operand A), 1 = rt (operand B).
  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             src_used;

  assign src[0]   = id_rs;
  assign src[1]   = id_rt;
  assign src_used = {id_rt_used, id_rs_used};

  // Load-use detection: a load in EX whose result the ID instruction reads.
  // Register $0 never stalls.
  always_comb begin
    lu = id_valid & ~id_flush & ex_wen_reg & ex_load_reg & (ex_dst_reg != '0) &
         ((id_rs_used & (id_rs == ex_dst_reg)) | (id_rt_used & (id_rt == ex_dst_reg)));
  end

  assign bubble = ~id_valid | id_flush | lu;
  assign stall  = lu | mem_hold;

  // Pipeline shadow advance: MEM takes EX, EX takes ID or a bubble; frozen on mem_hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_dst_reg  <= '0;
      ex_wen_reg  <= 1'b0;
      ex_load_reg <= 1'b0;
      mem_dst_reg <= '0;
      mem_wen_reg <= 1'b0;
    end else if (!mem_hold) begin
      mem_dst_reg <= ex_dst_reg;
      mem_wen_reg <= ex_wen_reg;
      if (bubble) begin
        ex_dst_reg  <= '0;
        ex_wen_reg  <= 1'b0;
        ex_load_reg <= 1'b0;
      end else begin
        ex_dst_reg  <= id_dst;
        ex_wen_reg  <= id_wen;
        ex_load_reg <= id_is_load;
      end
    end
  end

  // Saturating count of edges on which a load-use bubble is inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!mem_hold && lu && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign load_use_cnt = cnt_reg;

  // One select generator per source operand.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [1:0] sel_next;
      logic [1:0] sel_reg;

      // Youngest producer wins; a load in EX never matches here because lu
      // has already turned this instruction into a bubble.
      always_comb begin
        sel_next = 2'd0;
        if (!bubble && src_used[gi] && (src[gi] != '0)) begin
          if (ex_wen_reg && (ex_dst_reg == src[gi])) begin
            sel_next = 2'd1;
          end else if (mem_wen_reg && (mem_dst_reg == src[gi])) begin
            sel_next = 2'd2;
          end
        end
      end

      // Select captured on the same edge the instruction enters EX.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sel_reg <= 2'd0;
        end else if (!mem_hold) begin
          sel_reg <= sel_next;
        end
      end
    end
  endgenerate

  assign fwd_a_sel = g_src[0].sel_reg;
  assign fwd_b_sel = g_src[1].sel_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: hand-computed selects, stall and counter.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic [4:0]  id_dst;
  logic        id_wen;
  logic        id_is_load;
  logic        id_flush;
  logic        mem_hold;
  logic        stall;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] load_use_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_dst       (id_dst),
    .id_wen       (id_wen),
    .id_is_load   (id_is_load),
    .id_flush     (id_flush),
    .mem_hold     (mem_hold),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .load_use_cnt (load_use_cnt)
  );

  always #5 clk = ~clk;

  // Present one instruction in ID (no clock advance).
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic [4:0] dst,
                       input logic wen, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_dst = dst; id_wen = wen; id_is_load = ld; id_flush = fl;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("  txn t=%0t stall=%0b a=%0d b=%0d cnt=%0d", $time, stall, fwd_a_sel, fwd_b_sel, load_use_cnt);
  endtask

  task automatic test_reset();
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL reset_a: got %0d want 0", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL reset_b: got %0d want 0", fwd_b_sel); end
    n_checks++; if (load_use_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", load_use_cnt); end
  endtask

  // add r3 then consumer reading r3 in the next cycle -> EX/MEM forward (1).
  task automatic test_fwd_ex();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3,r1,r2
    issue(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); step();           // add r4,r3,r5
    n_checks++; if (fwd_a_sel !== 2'd1) begin n_errors++; $display("FAIL ex_fwd_a: got %0d want 1", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL ex_fwd_a_b: got %0d want 0", fwd_b_sel); end
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3,r1,r2
    issue(1, 5'd5, 5'd3, 1, 1, 5'd4, 1, 0, 0); step();           // add r4,r5,r3
    n_checks++; if (fwd_b_sel !== 2'd1) begin n_errors++; $display("FAIL ex_fwd_b: got %0d want 1", fwd_b_sel); end
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL ex_fwd_b_a: got %0d want 0", fwd_a_sel); end
  endtask

  // Producer two ahead -> MEM/WB forward (2); EX producer beats MEM producer.
  task automatic test_fwd_mem();
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3
    nop(); step();
    issue(1, 5'd3, 5'd3, 1, 1, 5'd6, 1, 0, 0); step();           // sub r6,r3,r3
    n_checks++; if (fwd_a_sel !== 2'd2) begin n_errors++; $display("FAIL mem_fwd_a: got %0d want 2", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd2) begin n_errors++; $display("FAIL mem_fwd_b: got %0d want 2", fwd_b_sel); end
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3
    issue(1, 5'd3, 5'd3, 1, 1, 5'd8, 1, 0, 0); step();           // add r8,r3,r3
    n_checks++; if (fwd_a_sel !== 2'd1) begin n_errors++; $display("FAIL youngest_a: got %0d want 1", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd1) begin n_errors++; $display("FAIL youngest_b: got %0d want 1", fwd_b_sel); end
    nop(); step(); nop(); step();
  endtask

  // lw r5; add r7,r5,r1 -> one stall cycle, bubble, then MEM/WB forward.
  task automatic test_load_use();
    issue(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);                   // lw r5,0(r1)
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_pre_stall: got %0b want 0", stall); end
    step();
    issue(1, 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 0);                   // add r7,r5,r1
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL lu_bubble: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel); end
    n_checks++; if (load_use_cnt !== 16'd1) begin n_errors++; $display("FAIL lu_cnt: got %0d want 1", load_use_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_once: got %0b want 0", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd2) begin n_errors++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL lu_fwd_b: got %0d want 0", fwd_b_sel); end
    n_checks++; if (load_use_cnt !== 16'd1) begin n_errors++; $display("FAIL lu_cnt_after: got %0d want 1", load_use_cnt); end
    nop(); step(); nop(); step();
  endtask

  // $0 never forwards or stalls; mem_hold freezes every output.
  task automatic test_r0_and_hold();
    issue(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0); step();           // lw r0
    issue(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0);                   // add r9,r0,r0
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL r0_stall: got %0b want 0", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL r0_sel: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel); end
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();           // add r3
    issue(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); step();           // add r4,r3,r5 -> a=1
    issue(1, 5'd4, 5'd3, 1, 1, 5'd10, 1, 0, 0);                  // add r10,r4,r3
    mem_hold = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hold_stall: got %0b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0 || load_use_cnt !== 16'd1) begin
        n_errors++; $display("FAIL hold_frozen[%0d]: got a=%0d b=%0d cnt=%0d want a=1 b=0 cnt=1", i, fwd_a_sel, fwd_b_sel, load_use_cnt);
      end
    end
    mem_hold = 1'b0; #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL hold_release_stall: got %0b want 0", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd2) begin n_errors++; $display("FAIL hold_resume: got a=%0d b=%0d want a=1 b=2", fwd_a_sel, fwd_b_sel); end
    nop(); step(); nop(); step();
  endtask

  // Flushed consumer behind a load: no stall, bubble, counter unchanged.
  task automatic test_flush();
    issue(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0); step();           // lw r5
    issue(1, 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 1);                   // add r7,r5,r1 flushed
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_stall: got %0b want 0", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd0 || load_use_cnt !== 16'd1) begin n_errors++; $display("FAIL flush_bubble: got a=%0d cnt=%0d want a=0 cnt=1", fwd_a_sel, load_use_cnt); end
    issue(1, 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 0);                   // refetched consumer
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_refetch_stall: got %0b want 0", stall); end
    step();
    n_checks++; if (fwd_a_sel !== 2'd2) begin n_errors++; $display("FAIL flush_refetch_a: got %0d want 2", fwd_a_sel); end
    nop(); step(); nop(); step();
  endtask

  // Asynchronous reset while a load-use stall is active.
  task automatic test_reset_mid_stall();
    issue(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0); step();           // lw r5
    issue(1, 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 0);                   // consumer
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_pre_stall: got %0b want 1", stall); end
    step();                                                      // cnt -> 2
    issue(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0); step();           // lw r5 again
    issue(1, 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 0);
    n_checks++; if (stall !== 1'b1 || load_use_cnt !== 16'd2) begin n_errors++; $display("FAIL rst_pre_state: got stall=%0b cnt=%0d want stall=1 cnt=2", stall, load_use_cnt); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || load_use_cnt !== 16'd0) begin
      n_errors++; $display("FAIL rst_async: got stall=%0b a=%0d b=%0d cnt=%0d want all 0", stall, fwd_a_sel, fwd_b_sel, load_use_cnt);
    end
    nop();
    rst = 1'b0;
    step();
    n_checks++; if (stall !== 1'b0 || fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || load_use_cnt !== 16'd0) begin
      n_errors++; $display("FAIL rst_idle: got stall=%0b a=%0d b=%0d cnt=%0d want all 0", stall, fwd_a_sel, fwd_b_sel, load_use_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_hold = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_r0_and_hold();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
